poly_eval: RTL

POLY_EVAL -- requirements
Module: poly_eval

---
 rtl/poly_eval_pkg.sv | 29 ++
 rtl/poly_eval_if.sv | 46 ++++
 rtl/poly_eval_datapath.sv | 124 ++++++++++++
 rtl/poly_eval.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/poly_eval_pkg.sv
// -----------------------------------------------------------------------------
// poly_eval_pkg
// Shared definitions for the Horner-scheme polynomial evaluator:
//   - legal range of the DEGREE parameter
//   - width of the operand slot index (slots 0..DEGREE+1)
//   - FSM state encoding
//   - helper to validate DEGREE at elaboration time
// -----------------------------------------------------------------------------
package poly_eval_pkg;

  localparam int DEGREE_MIN = 1;
  localparam int DEGREE_MAX = 7;

  // Slot N+1 holds x, so the index must reach DEGREE_MAX+1 (= 8).
  localparam int IDX_W = $clog2(DEGREE_MAX + 2);

  typedef enum logic [2:0] {
    S_LOAD      = 3'd0,
    S_LOAD_WAIT = 3'd1,
    S_MUL       = 3'd2,
    S_ADD       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  function automatic logic degree_ok(input int degree);
    return (degree >= DEGREE_MIN) && (degree <= DEGREE_MAX);
  endfunction

endpackage

// File: rtl/poly_eval_if.sv
// -----------------------------------------------------------------------------
// poly_eval_if
// Operator-side bundle of the polynomial evaluator.
//   go          : load/step strobe (level, held by operator)
//   data_in     : coefficient or x value captured on a load
//   load_idx    : next operand slot (0..N = a_N..a_0, N+1 = x)
//   busy        : high while evaluating
//   done        : one-cycle pulse when data_result/overflow update
//   data_result : last completed p(x) mod 2^WIDTH
//   overflow    : some intermediate of the last evaluation exceeded WIDTH bits
// Modports: master = operator, slave = evaluator.
// -----------------------------------------------------------------------------
interface poly_eval_if #(
  parameter int WIDTH = 8
);
  import poly_eval_pkg::*;

  logic             go;
  logic [WIDTH-1:0] data_in;
  logic [IDX_W-1:0] load_idx;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_result;
  logic             overflow;

  modport master (
    output go,
    output data_in,
    input  load_idx,
    input  busy,
    input  done,
    input  data_result,
    input  overflow
  );

  modport slave (
    input  go,
    input  data_in,
    output load_idx,
    output busy,
    output done,
    output data_result,
    output overflow
  );

endinterface

// File: rtl/poly_eval_datapath.sv
// -----------------------------------------------------------------------------
// poly_eval_datapath
// Operand register file (a_N..a_0 in slots 0..N, x in slot N+1), Horner
// accumulator, single-cycle multiply/add unit, sticky overflow and the
// result/done output registers.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   data_in       : value written to slot load_slot when load_en
//   start         : acc <= a_N, clear sticky overflow
//   mul_en        : acc <= acc * x
//   add_en        : acc <= acc + a_i (i = add_idx)
//   commit        : latch acc/sticky into data_result/overflow, pulse done
// -----------------------------------------------------------------------------
module poly_eval_datapath
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_slot,
  input  logic             start,
  input  logic             mul_en,
  input  logic             add_en,
  input  logic [2:0]       add_idx,
  input  logic             commit,
  output logic [WIDTH-1:0] data_result,
  output logic             overflow,
  output logic             done
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = WIDTH + 1;

  logic [WIDTH-1:0] slot_val [0:DEGREE+1];
  logic [WIDTH-1:0] x_val;
  logic [WIDTH-1:0] coef_sel;

  logic [WIDTH-1:0] acc_reg;
  logic             sticky_reg;
  logic [WIDTH-1:0] result_reg;
  logic             ovf_out_reg;
  logic             done_reg;

  logic [PW-1:0]    prod_full;
  logic [SW-1:0]    sum_full;
  logic             prod_ovf;
  logic             sum_ovf;

  // One register per operand slot; each decodes its own write enable.
  genvar gi;
  generate
    for (gi = 0; gi <= DEGREE + 1; gi++) begin : g_slot
      localparam logic [IDX_W-1:0] SLOT_ID = IDX_W'(gi);
      logic [WIDTH-1:0] val_reg;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          val_reg <= '0;
        end else if (load_en && (load_slot == SLOT_ID)) begin
          val_reg <= data_in;
        end
      end

      assign slot_val[gi] = val_reg;
    end
  endgenerate

  assign x_val = slot_val[DEGREE+1];

  // a_i lives in slot DEGREE-i.
  always_comb begin
    coef_sel = '0;
    for (int k = 0; k <= DEGREE; k++) begin
      if (add_idx == 3'(DEGREE - k)) begin
        coef_sel = slot_val[k];
      end
    end
  end

  // Full-precision results; the upper bits only feed overflow detection.
  assign prod_full = PW'(acc_reg) * PW'(x_val);
  assign sum_full  = SW'(acc_reg) + SW'(coef_sel);
  assign prod_ovf  = |prod_full[PW-1:WIDTH];
  assign sum_ovf   = sum_full[WIDTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_reg     <= '0;
      sticky_reg  <= 1'b0;
      result_reg  <= '0;
      ovf_out_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= commit;
      if (start) begin
        acc_reg    <= slot_val[0];
        sticky_reg <= 1'b0;
      end else if (mul_en) begin
        acc_reg <= prod_full[WIDTH-1:0];
        if (prod_ovf) begin
          sticky_reg <= 1'b1;
        end
      end else if (add_en) begin
        acc_reg <= sum_full[WIDTH-1:0];
        if (sum_ovf) begin
          sticky_reg <= 1'b1;
        end
      end
      if (commit) begin
        result_reg  <= acc_reg;
        ovf_out_reg <= sticky_reg;
      end
    end
  end

  assign data_result = result_reg;
  assign overflow    = ovf_out_reg;
  assign done        = done_reg;

endmodule

// File: rtl/poly_eval.sv
// -----------------------------------------------------------------------------
// poly_eval
// Sequential polynomial evaluator p(x) = a_N x^N + ... + a_0 using Horner's
// scheme, one multiply and one add per coefficient step.
// The operator loads N+1 coefficients (highest first) and then x, one value
// per go press/release. Releasing go after x starts the evaluation
// (2*N MUL/ADD cycles plus one DONE cycle).
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : poly_eval_if.slave (go, data_in, load_idx, busy, done,
//            data_result, overflow)
// -----------------------------------------------------------------------------
module poly_eval
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 3
) (
  input  logic        clk,
  input  logic        resetn,
  poly_eval_if.slave  bus
);

  localparam logic [IDX_W-1:0] X_SLOT  = IDX_W'(DEGREE + 1);
  localparam logic [2:0]       I_START = 3'(DEGREE - 1);

  generate
    if (!degree_ok(DEGREE)) begin : g_bad_degree
      $error("poly_eval: DEGREE must lie in 1..7");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] slot_reg, slot_next;
  logic [2:0]       i_reg, i_next;

  logic load_en;
  logic start;
  logic mul_en;
  logic add_en;
  logic commit;
  logic busy;

  // State and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_LOAD;
      slot_reg  <= '0;
      i_reg     <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      i_reg     <= i_next;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    i_next     = i_reg;
    case (state_reg)
      S_LOAD: begin
        if (bus.go) begin
          state_next = S_LOAD_WAIT;
        end
      end
      S_LOAD_WAIT: begin
        // Advance only on release so one press writes exactly one slot.
        if (!bus.go) begin
          if (slot_reg == X_SLOT) begin
            state_next = S_MUL;
            i_next     = I_START;
          end else begin
            slot_next  = slot_reg + 1'b1;
            state_next = S_LOAD;
          end
        end
      end
      S_MUL: begin
        state_next = S_ADD;
      end
      S_ADD: begin
        if (i_reg == 3'd0) begin
          state_next = S_DONE;
        end else begin
          i_next     = i_reg - 1'b1;
          state_next = S_MUL;
        end
      end
      S_DONE: begin
        slot_next  = '0;
        state_next = S_LOAD;
      end
      default: begin
        state_next = S_LOAD;
        slot_next  = '0;
      end
    endcase
  end

  // Datapath controls. The overflow flag is cleared once per evaluation
  // (together with acc <= a_N), so it stays sticky across all MUL/ADD steps.
  always_comb begin
    load_en = 1'b0;
    start   = 1'b0;
    mul_en  = 1'b0;
    add_en  = 1'b0;
    commit  = 1'b0;
    busy    = 1'b0;
    case (state_reg)
      S_LOAD:      load_en = bus.go;
      S_LOAD_WAIT: start   = !bus.go && (slot_reg == X_SLOT);
      S_MUL: begin
        mul_en = 1'b1;
        busy   = 1'b1;
      end
      S_ADD: begin
        add_en = 1'b1;
        busy   = 1'b1;
      end
      S_DONE:      commit  = 1'b1;
      default:     ;
    endcase
  end

  poly_eval_datapath #(
    .WIDTH  (WIDTH),
    .DEGREE (DEGREE)
  ) u_datapath (
    .clk         (clk),
    .resetn      (resetn),
    .data_in     (bus.data_in),
    .load_en     (load_en),
    .load_slot   (slot_reg),
    .start       (start),
    .mul_en      (mul_en),
    .add_en      (add_en),
    .add_idx     (i_reg),
    .commit      (commit),
    .data_result (bus.data_result),
    .overflow    (bus.overflow),
    .done        (bus.done)
  );

  assign bus.load_idx = slot_reg;
  assign bus.busy     = busy;

endmodule
